// File: rtl/sram_dp.sv
// Simple dual-port synchronous SRAM: one byte-enabled write port, one read port,
// selectable read latency (1 or 2) and defined same-address read-during-write.
module sram_dp #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 1048576,
   parameter int ADDR_W   = 20,
   parameter int RD_LAT   = 1,
   parameter int RDW_MODE = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr_en,
   input  logic [ADDR_W-1:0]     i_wr_addr,
   input  logic [DATA_W/8-1:0]   i_wr_be,
   input  logic [DATA_W-1:0]     i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_W-1:0]     i_rd_addr,
   output logic [DATA_W-1:0]     o_rd_data,
   output logic                  o_rd_valid
);

   localparam int              NB        = DATA_W / 8;
   localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

   generate
      if (DATA_W % 8 != 0) begin : g_bad_data_w
         $fatal(1, "sram_dp: DATA_W must be a multiple of 8");
      end
      if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
         $fatal(1, "sram_dp: RD_LAT must be 1 or 2");
      end
      if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
         $fatal(1, "sram_dp: 2**ADDR_W must be >= DEPTH");
      end
   endgenerate

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_ram_q;

   logic              w_wr_ok;
   logic              w_rd_in_range;
   logic              w_coll;
   logic [IDX_W-1:0]  w_wr_idx;
   logic [IDX_W-1:0]  w_rd_idx;

   assign w_wr_ok       = i_wr_en && ({1'b0, i_wr_addr} < DEPTH_LIM);
   assign w_rd_in_range = {1'b0, i_rd_addr} < DEPTH_LIM;
   assign w_coll        = w_wr_ok && i_rd_en && (i_wr_addr == i_rd_addr);
   assign w_wr_idx      = i_wr_addr[IDX_W-1:0];
   assign w_rd_idx      = i_rd_addr[IDX_W-1:0];

   // Array and its read register carry no reset so they map onto block RAM;
   // the non-blocking read naturally yields the pre-write word on collision.
   always_ff @(posedge i_clk) begin
      if (w_wr_ok) begin
         for (int b = 0; b < NB; b++) begin
            if (i_wr_be[b]) begin
               r_mem[w_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
            end
         end
      end
      if (i_rd_en) begin
         r_ram_q <= r_mem[w_rd_idx];
      end
   end

   // Stage-1 side-band: everything needed to resolve the RAM word afterwards.
   logic              r_s1_valid;
   logic              r_s1_loaded;
   logic              r_s1_coll;
   logic              r_s1_oor;
   logic [NB-1:0]     r_s1_be;
   logic [DATA_W-1:0] r_s1_wdata;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_loaded <= 1'b0;
         r_s1_coll   <= 1'b0;
         r_s1_oor    <= 1'b0;
         r_s1_be     <= '0;
         r_s1_wdata  <= '0;
      end else begin
         r_s1_valid <= i_rd_en;
         if (i_rd_en) begin
            r_s1_loaded <= 1'b1;
            r_s1_coll   <= w_coll;
            r_s1_oor    <= !w_rd_in_range;
            r_s1_be     <= i_wr_be;
            r_s1_wdata  <= i_wr_data;
         end
      end
   end

   logic [DATA_W-1:0] w_s1_merged;
   logic [DATA_W-1:0] w_s1_value;

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         assign w_s1_merged[gi*8 +: 8] =
            (RDW_MODE == 1 && r_s1_coll && r_s1_be[gi]) ? r_s1_wdata[gi*8 +: 8]
                                                         : r_ram_q[gi*8 +: 8];
      end
   endgenerate

   // Until the first read after reset the output reads as zero.
   assign w_s1_value = (!r_s1_loaded || r_s1_oor) ? '0 : w_s1_merged;

   generate
      if (RD_LAT == 1) begin : g_lat1
         assign o_rd_data  = w_s1_value;
         assign o_rd_valid = r_s1_valid;
      end else begin : g_lat2
         logic [DATA_W-1:0] r_rd_data;
         logic              r_rd_valid;

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_rd_data  <= '0;
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= r_s1_valid;
               if (r_s1_valid) begin
                  r_rd_data <= w_s1_value;
               end
            end
         end

         assign o_rd_data  = r_rd_data;
         assign o_rd_valid = r_rd_valid;
      end
   endgenerate

endmodule

// File: tb/tb_sram_dp.sv
// Directed bench for sram_dp: four instances (RD_LAT x RDW_MODE) share stimulus,
// expected reads are queued at issue time and popped when they fall due.
module tb_sram_dp;

   localparam int DW  = 32;
   localparam int AW  = 10;
   localparam int DEP = 1000;
   localparam int NI  = 4;

   typedef struct {
      int          inst;
      int          due;
      logic [31:0] data;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [3:0]    wr_be;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data  [NI];
   logic          rd_valid [NI];

   exp_t          sb[$];
   logic [31:0]   last_data [NI];
   int            cyc;
   int            n_pass;
   int            n_fail;
   int            n_total;

   sram_dp #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .RD_LAT(1), .RDW_MODE(0)) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
      .i_wr_be(wr_be), .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
      .o_rd_data(rd_data[0]), .o_rd_valid(rd_valid[0]));
   sram_dp #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .RD_LAT(1), .RDW_MODE(1)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
      .i_wr_be(wr_be), .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
      .o_rd_data(rd_data[1]), .o_rd_valid(rd_valid[1]));
   sram_dp #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .RD_LAT(2), .RDW_MODE(0)) u2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
      .i_wr_be(wr_be), .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
      .o_rd_data(rd_data[2]), .o_rd_valid(rd_valid[2]));
   sram_dp #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .RD_LAT(2), .RDW_MODE(1)) u3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
      .i_wr_be(wr_be), .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
      .o_rd_data(rd_data[3]), .o_rd_valid(rd_valid[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat_of(input int i);
      return (i < 2) ? 1 : 2;
   endfunction

   function automatic int mode_of(input int i);
      return i % 2;
   endfunction

   task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s inst%0d cyc%0d observed=%h expected=%h", tag, inst, cyc, obs, exp);
      end
   endtask

   // Every cycle each instance either delivers its oldest due read or stays idle holding data.
   task automatic check_outputs();
      for (int i = 0; i < NI; i++) begin
         int idx;
         idx = -1;
         for (int k = 0; k < sb.size(); k++) begin
            if (idx < 0 && sb[k].inst == i) idx = k;
         end
         if (idx >= 0 && sb[idx].due <= cyc) begin
            chk("rd_valid_hi", i, {31'b0, rd_valid[i]}, 32'd1);
            chk("rd_data", i, rd_data[i], sb[idx].data);
            last_data[i] = sb[idx].data;
            sb.delete(idx);
         end else begin
            chk("rd_valid_lo", i, {31'b0, rd_valid[i]}, 32'd0);
            chk("rd_data_hold", i, rd_data[i], last_data[i]);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [3:0] be,
                        input logic [31:0] wd, input logic re, input logic [AW-1:0] ra,
                        input logic [31:0] e_old, input logic [31:0] e_new);
      exp_t e;
      wr_en   = we;
      wr_addr = wa;
      wr_be   = be;
      wr_data = wd;
      rd_en   = re;
      rd_addr = ra;
      if (re) begin
         for (int i = 0; i < NI; i++) begin
            e.inst = i;
            e.due  = cyc + lat_of(i);
            e.data = (mode_of(i) == 1) ? e_new : e_old;
            sb.push_back(e);
         end
      end
      tick();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, '0, 4'h0, '0, 1'b0, '0, '0, '0);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
      cycle(1'b1, a, be, d, 1'b0, '0, '0, '0);
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [31:0] d);
      cycle(1'b0, '0, 4'h0, '0, 1'b1, a, d, d);
   endtask

   initial begin
      cyc = 0; n_pass = 0; n_fail = 0; n_total = 0;
      for (int i = 0; i < NI; i++) last_data[i] = '0;
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr = '0;

      // Reset state: outputs zero, no valid
      tick();
      tick();
      rst_n = 1'b1;
      idle(1);

      // Basic write then read
      wr(10'h010, 4'hF, 32'hDEADBEEF);
      idle(1);
      rd(10'h010, 32'hDEADBEEF);
      idle(2);

      // Byte-lane merge and be=0 no-op
      wr(10'd5, 4'hF, 32'h11223344);
      wr(10'd5, 4'h5, 32'hAABBCCDD);
      rd(10'd5, 32'h11BB33DD);
      wr(10'd5, 4'h0, 32'hFFFFFFFF);
      rd(10'd5, 32'h11BB33DD);
      idle(2);

      // Same-address read-during-write, then read on the following edge
      wr(10'd7, 4'hF, 32'h00000001);
      cycle(1'b1, 10'd7, 4'h3, 32'hFFFFFFFF, 1'b1, 10'd7, 32'h00000001, 32'h0000FFFF);
      rd(10'd7, 32'h0000FFFF);
      idle(2);

      // Back-to-back streaming reads
      for (int a = 0; a < 8; a++) wr(10'(a), 4'hF, 32'(a) * 32'h01010101);
      for (int a = 0; a < 8; a++) rd(10'(a), 32'(a) * 32'h01010101);
      idle(3);

      // Out-of-range write dropped, out-of-range read returns zero
      wr(10'd999, 4'hF, 32'hCAFEF00D);
      wr(10'd1000, 4'hF, 32'h12345678);
      rd(10'd1000, 32'h00000000);
      rd(10'd999, 32'hCAFEF00D);
      cycle(1'b1, 10'd1000, 4'hF, 32'h12345678, 1'b1, 10'd1000, 32'h0, 32'h0);
      idle(2);

      // Reset while a read is in flight
      rd(10'd3, 32'h03030303);
      rd_en = 1'b0;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         chk("async_rst_valid", i, {31'b0, rd_valid[i]}, 32'd0);
         chk("async_rst_data", i, rd_data[i], 32'd0);
         last_data[i] = '0;
      end
      sb.delete();
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      rd(10'd3, 32'h03030303);
      rd(10'd999, 32'hCAFEF00D);
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sram_dp.md
Name: sram_dp

Overview:
- Parametrised simple dual-port synchronous SRAM: one write port and one independent read port on a single clock.
- Next generation of the frame-buffer memory used by the image-rotate datapath. The rotator writes source pixels while it reads rotated pixels in the same cycle.
- Adds byte-lane write enables, selectable read latency (1 or 2), a defined same-address read-during-write result, and a read-valid strobe.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 1048576, number of words; need not be a power of two.
- ADDR_W, 20, address width; must satisfy 2**ADDR_W >= DEPTH.
- RD_LAT, 1, read latency in clock edges; legal values are 1 or 2.
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new data merged by byte enable.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request, sampled at posedge.
- wr_addr  input  ADDR_W  write word address.
- wr_be  input  DATA_W/8  byte-lane enables; bit i covers wr_data[8i+7:8i].
- wr_data  input  DATA_W  write data.
- rd_en  input  1  read request, sampled at posedge.
- rd_addr  input  ADDR_W  read word address.
- rd_data  output  DATA_W  read data, registered.
- rd_valid  output  1  high for exactly one cycle per accepted read, aligned with rd_data.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - rd_data = 0 and rd_valid = 0.
  - All read-pipeline stage registers (data, valid, collision flags) clear to 0.
  - Memory array is NOT reset; contents survive rst_n assertion.
- Write:
  - Taken at posedge when wr_en=1 and wr_addr < DEPTH.
  - Only lanes with wr_be[i]=1 are updated; other lanes keep their value.
  - wr_be = 0 is a legal no-op.
  - wr_addr >= DEPTH: write is silently dropped.
- Read, RD_LAT=1:
  - rd_en=1 sampled at edge N; rd_data and rd_valid are updated at edge N.
  - Both are visible during cycle N+1.
- Read, RD_LAT=2:
  - Array read registered at edge N into stage 1; stage 1 transferred to rd_data/rd_valid at edge N+1.
  - Fully pipelined: one read per cycle, back-to-back, no bubbles.
- No read in a cycle:
  - rd_valid drops to 0 in the corresponding output cycle.
  - rd_data holds its last value; it is not cleared.
- Read with rd_addr >= DEPTH: returns 0 with rd_valid=1.
- Same-cycle collision (wr_en & rd_en, wr_addr == rd_addr < DEPTH):
  - RDW_MODE=0: read returns the word as it was before this edge's write.
  - RDW_MODE=1: read returns, per lane, wr_data where wr_be=1, otherwise the old word.
  - For RD_LAT=2, the merge is resolved in stage 1 and carried forward.
- Write at edge N to address A, read of A at edge N+1 or later: returns the new data in both modes.
- Reset mid-operation:
  - Reads in flight are discarded; no rd_valid pulse emerges after rst_n deasserts.
  - A write sampled on the same edge that rst_n asserts is not guaranteed; the bench must not rely on it.
  - First accepted read after rst_n rises behaves normally with full RD_LAT.
- Reading a never-written word returns undefined content (X in simulation); the bench must not check it.
- Elaboration checks:
  - Fatal error if DATA_W % 8 != 0, RD_LAT not in {1,2}, or 2**ADDR_W < DEPTH.
- Array inference: single write-port plus single read-port array. No reset in the array's always block, so synthesis infers block RAM.

Test Plan:
- Write/read, RD_LAT=1: write 0xDEADBEEF to 0x00010, be=0xF; read 0x00010 two cycles later -> rd_data=0xDEADBEEF with rd_valid=1 exactly one cycle after the rd_en edge.
- Byte lanes: write 0x11223344 (be=0xF) to addr 5, then 0xAABBCCDD with be=0x5; read addr 5 -> 0x11BB33DD.
- Collision:
  - Addr 7 holds 0x00000001; same cycle, write 0xFFFFFFFF (be=0x3) and read addr 7.
  - RDW_MODE=0 -> 0x00000001; RDW_MODE=1 -> 0x0000FFFF.
- RD_LAT=2 streaming: write addrs 0..7 with data addr*0x01010101; issue rd_en for 0..7 on consecutive cycles -> rd_valid high for 8 consecutive cycles starting 2 cycles after first rd_en; rd_data 0x00000000..0x07070707 in order.
- Reset mid-read: RD_LAT=2, issue read of addr 3, assert rst_n low before the data emerges -> rd_valid stays 0 and rd_data=0. After release, re-read addr 3 -> prior contents (0x03030303) intact.
- Out of range with DEPTH=1000, ADDR_W=10:
  - Write 0x12345678 to addr 1000 -> dropped.
  - Read addr 1000 -> rd_data=0, rd_valid=1.
  - Read addr 999 is unaffected.
